// File: rtl/store_one_block.sv
// Drains one Tn x Tn result tile into the row-major N x N C memory at a tile origin.
// Build option WB_ACCUM_EN: read-modify-write (C += tile), two cycles per element.
module store_one_block #(
    parameter int Tn = 4,
    parameter int N  = 16,
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    block_row,
    input  logic [7:0]    block_col,
    input  logic [DW-1:0] block [0:Tn-1][0:Tn-1],
    input  logic [DW-1:0] dinc,
    output logic [AW-1:0] addrc,
    output logic [DW-1:0] doutc,
    output logic          wec,
    output logic          busy,
    output logic          done
);

    localparam int CW = (Tn > 1) ? $clog2(Tn) : 1;
    localparam logic [CW-1:0] LAST = CW'(Tn - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] i_q, i_d, j_q, j_d;
    logic [CW-1:0] i_nx, j_nx;
    logic [7:0]    row_q, row_d, col_q, col_d;
    logic [DW-1:0] snap_q [0:Tn-1][0:Tn-1];
    logic [DW-1:0] snap_d [0:Tn-1][0:Tn-1];
    logic [AW-1:0] addrc_q, addrc_d;
    logic [DW-1:0] doutc_q, doutc_d;
    logic          wec_q, wec_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          last_elem;

    function automatic logic [AW-1:0] elem_addr(input logic [7:0] r, input logic [7:0] c,
                                                input logic [CW-1:0] ii, input logic [CW-1:0] jj);
        logic [31:0] s;
        s = (32'(r) + 32'(ii)) * 32'(N) + 32'(c) + 32'(jj);
        return s[AW-1:0];
    endfunction

    assign last_elem = (i_q == LAST) && (j_q == LAST);
    assign j_nx      = (j_q == LAST) ? '0 : j_q + 1'b1;
    assign i_nx      = (j_q == LAST) ? i_q + 1'b1 : i_q;

`ifdef WB_ACCUM_EN
    logic [DW-1:0] addend_q, addend_d;
    logic [DW-1:0] doutc_sum;

    // dinc only arrives in the write cycle itself, so the sum is formed there
    // from a registered addend; doutc_q keeps the value once the write is over.
    assign doutc_sum = dinc + addend_q;
    assign doutc     = wec_q ? doutc_sum : doutc_q;
`else
    logic unused_dinc;
    assign unused_dinc = ^dinc;
    assign doutc       = doutc_q;
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        row_d   = row_q;
        col_d   = col_q;
        snap_d  = snap_q;
        addrc_d = addrc_q;
        doutc_d = doutc_q;
        wec_d   = 1'b0;
        done_d  = 1'b0;
`ifdef WB_ACCUM_EN
        addend_d = addend_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = block;
                    row_d   = block_row;
                    col_d   = block_col;
                    i_d     = '0;
                    j_d     = '0;
                    addrc_d = elem_addr(block_row, block_col, '0, '0);
`ifdef WB_ACCUM_EN
                    state_d = READ;
`else
                    state_d = WRITE;
                    wec_d   = 1'b1;
                    doutc_d = block[0][0];
`endif
                end
            end
`ifdef WB_ACCUM_EN
            READ: begin
                state_d  = WRITE;
                wec_d    = 1'b1;
                addend_d = snap_q[i_q][j_q];
            end
`endif
            WRITE: begin
`ifdef WB_ACCUM_EN
                doutc_d = doutc_sum;
`endif
                if (last_elem) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    i_d     = i_nx;
                    j_d     = j_nx;
                    addrc_d = elem_addr(row_q, col_q, i_nx, j_nx);
`ifdef WB_ACCUM_EN
                    state_d = READ;
`else
                    wec_d   = 1'b1;
                    doutc_d = snap_q[i_nx][j_nx];
`endif
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            addrc_q <= '0;
            doutc_q <= '0;
            wec_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef WB_ACCUM_EN
            addend_q <= '0;
`endif
            for (int a = 0; a < Tn; a++) begin
                for (int b = 0; b < Tn; b++) begin
                    snap_q[a][b] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addrc_q <= addrc_d;
            doutc_q <= doutc_d;
            wec_q   <= wec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef WB_ACCUM_EN
            addend_q <= addend_d;
`endif
            snap_q  <= snap_d;
        end
    end

    assign addrc = addrc_q;
    assign wec   = wec_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
